// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults for the single-clock FIFO.
//   FIFO_WIDTH      default data word width
//   FIFO_DEPTH      default number of storage entries (2**FIFO_PTR_WIDTH)
//   FIFO_PTR_WIDTH  default storage address width
//   fifo_ptr_t      pointer type: address bits plus one wrap bit
package fifo_pkg;

    localparam int FIFO_WIDTH     = 8;
    localparam int FIFO_PTR_WIDTH = 4;
    localparam int FIFO_DEPTH     = 1 << FIFO_PTR_WIDTH;

    typedef logic [FIFO_PTR_WIDTH:0] fifo_ptr_t;

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x WIDTH register array with one synchronous write port and
// one synchronous read port. Storage is not reset; only the read register is.
// Ports:
//   wr_clk  in   clock
//   res     in   async active-low reset (clears rdata only)
//   we      in   write enable
//   waddr   in   write address
//   wdata   in   write data
//   re      in   read enable; rdata updates on the same edge
//   raddr   in   read address
//   rdata   out  registered read data, holds when re is low
module fifo_mem #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int PTR_WIDTH = 4
) (
    input  logic                 wr_clk,
    input  logic                 res,
    input  logic                 we,
    input  logic [PTR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic                 re,
    input  logic [PTR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]     rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge wr_clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge wr_clk or negedge res) begin
        if (!res) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with full/empty status and one-cycle
// over_flow/under_flow pulses for rejected accesses.
// Optional feature macro: FIFO_ALMOST_EN adds almost_full / almost_empty.
// Ports:
//   wr_clk        in   sole clock
//   res           in   async active-low reset
//   wr_en         in   write request
//   rd_en         in   read request
//   wdata         in   write data
//   rdata         out  registered read data (valid one cycle after accepted read)
//   empty         out  no entries stored
//   full          out  DEPTH entries stored
//   over_flow     out  pulse: write requested while full
//   under_flow    out  pulse: read requested while empty
//   almost_full   out  occupancy >= DEPTH-1   (FIFO_ALMOST_EN only)
//   almost_empty  out  occupancy <= 1         (FIFO_ALMOST_EN only)
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH     = FIFO_WIDTH,
    parameter int DEPTH     = FIFO_DEPTH,
    parameter int PTR_WIDTH = FIFO_PTR_WIDTH
) (
    input  logic             wr_clk,
    input  logic             res,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
`ifdef FIFO_ALMOST_EN
    output logic             almost_full,
    output logic             almost_empty,
`endif
    output logic             over_flow,
    output logic             under_flow
);

    logic [PTR_WIDTH:0] wr_ptr;
    logic [PTR_WIDTH:0] rd_ptr;
    logic               wr_acc;
    logic               rd_acc;

    // Equal addresses with differing wrap bits means the writer is one lap ahead.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_WIDTH-1:0] == rd_ptr[PTR_WIDTH-1:0]) &&
                   (wr_ptr[PTR_WIDTH] != rd_ptr[PTR_WIDTH]);

    // Acceptance uses pre-edge flags, so a read frees space only for the next cycle.
    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    always_ff @(posedge wr_clk or negedge res) begin
        if (!res) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            over_flow  <= 1'b0;
            under_flow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            over_flow  <= wr_en && full;
            under_flow <= rd_en && empty;
        end
    end

`ifdef FIFO_ALMOST_EN
    localparam logic [PTR_WIDTH:0] ALMOST_FULL_LVL = (PTR_WIDTH+1)'(DEPTH - 1);
    localparam logic [PTR_WIDTH:0] ALMOST_EMPTY_LVL = (PTR_WIDTH+1)'(1);

    logic [PTR_WIDTH:0] occupancy;

    // Modular subtraction over the wrap bit gives 0..DEPTH directly.
    assign occupancy    = wr_ptr - rd_ptr;
    assign almost_full  = (occupancy >= ALMOST_FULL_LVL);
    assign almost_empty = (occupancy <= ALMOST_EMPTY_LVL);
`endif

    fifo_mem #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_mem (
        .wr_clk (wr_clk),
        .res    (res),
        .we     (wr_acc),
        .waddr  (wr_ptr[PTR_WIDTH-1:0]),
        .wdata  (wdata),
        .re     (rd_acc),
        .raddr  (rd_ptr[PTR_WIDTH-1:0]),
        .rdata  (rdata)
    );

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed self-checking bench for sync_fifo (default parameters).
// Build with FIFO_ALMOST_EN defined to also exercise almost_full/almost_empty.
`timescale 1ns/1ps
module tb_sync_fifo;
    import fifo_pkg::*;

    logic       wr_clk;
    logic       res;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       empty;
    logic       full;
    logic       over_flow;
    logic       under_flow;
`ifdef FIFO_ALMOST_EN
    logic       almost_full;
    logic       almost_empty;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q [$];
    logic [7:0] exp_d;

    sync_fifo #(
        .WIDTH     (FIFO_WIDTH),
        .DEPTH     (FIFO_DEPTH),
        .PTR_WIDTH (FIFO_PTR_WIDTH)
    ) dut (
        .wr_clk       (wr_clk),
        .res          (res),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .wdata        (wdata),
        .rdata        (rdata),
        .empty        (empty),
        .full         (full),
`ifdef FIFO_ALMOST_EN
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
`endif
        .over_flow    (over_flow),
        .under_flow   (under_flow)
    );

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge and settle just after it; inputs stay as set.
    task automatic tick();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        wr_en = 1'b1;
        rd_en = 1'b0;
        wdata = d;
        tick();
        exp_q.push_back(d);
        wr_en = 1'b0;
    endtask

    initial begin
        res   = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        wdata = 8'h00;
        #2 res = 1'b0;
        tick();
        tick();
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_ovf", 32'(over_flow), 32'd0);
        chk("rst_udf", 32'(under_flow), 32'd0);
`ifdef FIFO_ALMOST_EN
        chk("rst_aempty", 32'(almost_empty), 32'd1);
        chk("rst_afull", 32'(almost_full), 32'd0);
`endif
        res = 1'b1;

        // Fill with 0x00..0x0F; full must rise only on the 16th edge.
        for (int i = 0; i < 16; i++) begin
            push(8'(i));
            chk($sformatf("fill_full_%0d", i), 32'(full), (i == 15) ? 32'd1 : 32'd0);
            chk($sformatf("fill_empty_%0d", i), 32'(empty), 32'd0);
        end

        // Write while full: rejected, one-cycle over_flow pulse.
        wr_en = 1'b1;
        wdata = 8'hAA;
        tick();
        chk("ovf_pulse", 32'(over_flow), 32'd1);
        chk("ovf_full", 32'(full), 32'd1);
        wr_en = 1'b0;
        tick();
        chk("ovf_clear", 32'(over_flow), 32'd0);

        // Drain: original data in order, 0xAA never appears.
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            exp_d = exp_q.pop_front();
            chk($sformatf("drain_data_%0d", i), 32'(rdata), 32'(exp_d));
            chk($sformatf("drain_empty_%0d", i), 32'(empty), (i == 15) ? 32'd1 : 32'd0);
        end

        // Read while empty: under_flow pulse, rdata holds 0x0F.
        tick();
        chk("udf_pulse", 32'(under_flow), 32'd1);
        chk("udf_rdata", 32'(rdata), 32'h0F);
        rd_en = 1'b0;
        tick();
        chk("udf_clear", 32'(under_flow), 32'd0);

        // Simultaneous read+write while empty: write wins, read rejected.
        rd_en = 1'b1;
        wr_en = 1'b1;
        wdata = 8'h55;
        tick();
        exp_q.push_back(8'h55);
        chk("rw_empty_udf", 32'(under_flow), 32'd1);
        chk("rw_empty_rdata", 32'(rdata), 32'h0F);
        chk("rw_empty_empty", 32'(empty), 32'd0);
        rd_en = 1'b0;
        wr_en = 1'b0;
        for (int i = 0; i < 4; i++) push(8'h60 + 8'(i));

        // Occupancy 5 with 20 cycles of simultaneous access; pointers wrap.
        rd_en = 1'b1;
        wr_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wdata = 8'h70 + 8'(i);
            tick();
            exp_q.push_back(wdata);
            exp_d = exp_q.pop_front();
            chk($sformatf("rw_data_%0d", i), 32'(rdata), 32'(exp_d));
            chk($sformatf("rw_flags_%0d", i), {30'd0, full, empty}, 32'd0);
            chk($sformatf("rw_errs_%0d", i), {30'd0, over_flow, under_flow}, 32'd0);
        end
        wr_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            exp_d = exp_q.pop_front();
            chk($sformatf("rw_tail_%0d", i), 32'(rdata), 32'(exp_d));
        end
        chk("rw_tail_empty", 32'(empty), 32'd1);
        rd_en = 1'b0;

        // Simultaneous read+write while full: read wins, write rejected.
        for (int i = 0; i < 16; i++) push(8'h80 + 8'(i));
        chk("rwf_full_pre", 32'(full), 32'd1);
        rd_en = 1'b1;
        wr_en = 1'b1;
        wdata = 8'hBB;
        tick();
        exp_d = exp_q.pop_front();
        chk("rwf_rdata", 32'(rdata), 32'(exp_d));
        chk("rwf_ovf", 32'(over_flow), 32'd1);
        chk("rwf_full", 32'(full), 32'd0);
`ifdef FIFO_ALMOST_EN
        chk("afull_15", 32'(almost_full), 32'd1);
        chk("aempty_15", 32'(almost_empty), 32'd0);
`endif
        wr_en = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            exp_d = exp_q.pop_front();
            chk($sformatf("rwf_drain_%0d", i), 32'(rdata), 32'(exp_d));
        end
        chk("rwf_drain_empty", 32'(empty), 32'd1);
        rd_en = 1'b0;

        // Fill 8 then reset mid-cycle: contents discarded immediately.
        for (int i = 0; i < 8; i++) push(8'hC0 + 8'(i));
        chk("mid_pre_empty", 32'(empty), 32'd0);
        #2 res = 1'b0;
        #1;
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_rdata", 32'(rdata), 32'd0);
        chk("mid_rst_full", 32'(full), 32'd0);
        exp_q.delete();
        tick();
        res = 1'b1;
        tick();
        chk("post_rst_empty", 32'(empty), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
